ex_divide_sequencer: RTL



---
 rtl/div_pkg.sv | 18 +
 rtl/div_restoring_step.sv | 24 ++
 rtl/ex_divide_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings for the EX-stage RV32M divide sequencer
package div_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] DIV_S = 2'b00;
  localparam logic [1:0] DIV_U = 2'b01;
  localparam logic [1:0] REM_S = 2'b10;
  localparam logic [1:0] REM_U = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one radix-2 restoring shift/compare/subtract iteration
module div_restoring_step
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_msb,
  input  logic [XLEN-1:0] i_dmag,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN-1:0] w_shift;
  logic            w_carry;

  // The bit shifted out of the partial remainder is kept as a carry so that
  // unsigned divisors above 2^(XLEN-1) still compare correctly.
  assign w_carry = i_rem[XLEN-1];
  assign w_shift = {i_rem[XLEN-2:0], i_dvd_msb};
  assign o_qbit  = w_carry | (w_shift >= i_dmag);
  assign o_rem   = o_qbit ? (w_shift - i_dmag) : w_shift;

endmodule

// File: rtl/ex_divide_sequencer.sv
// rtl/ex_divide_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU unit beside the EX ALU
module ex_divide_sequencer
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] DividendE,
  input  logic [XLEN-1:0] DivisorE,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            StallDivE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] DivResultE,
  output logic [4:0]      DivRdE,
  output logic            DivRegWriteE
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_dvd, r_dmag, r_rem, r_quot, r_result;
  logic             r_is_rem, r_neg_q, r_neg_r, r_done;
  logic [4:0]       r_rd, r_div_rd;

  logic            w_accept, w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_qbit;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special, w_rem_nxt, w_q_fix, w_r_fix;

  assign w_accept = (r_state == IDLE) & StartE & ~FlushE;
  assign w_signed = (DivOpE == DIV_S) | (DivOpE == REM_S);
  assign w_a_neg  = w_signed & DividendE[XLEN-1];
  assign w_b_neg  = w_signed & DivisorE[XLEN-1];
  assign w_a_mag  = w_a_neg ? -DividendE : DividendE;
  assign w_b_mag  = w_b_neg ? -DivisorE : DivisorE;
  assign w_div0   = (DivisorE == '0);
  assign w_ovf    = w_signed & (DividendE == MIN_NEG) & (DivisorE == '1);

  // Both early cases reuse the raw dividend: remainder for /0, quotient for overflow.
  always_comb begin
    w_special = '0;
    if (w_div0)
      w_special = ((DivOpE == REM_S) | (DivOpE == REM_U)) ? DividendE : '1;
    else
      w_special = ((DivOpE == REM_S) | (DivOpE == REM_U)) ? '0 : DividendE;
  end

  div_restoring_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[XLEN-1]),
    .i_dmag    (r_dmag),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_q_fix = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dmag   <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= '0;
      r_div_rd <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_rem <= DivOpE[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rd     <= RdE;
            r_dvd    <= w_a_mag;
            r_dmag   <= w_b_mag;
            r_rem    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            if (w_div0 | w_ovf) begin
              r_result <= w_special;
              r_div_rd <= RdE;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (FlushE) begin
            r_state <= IDLE;
          end else begin
            r_rem  <= w_rem_nxt;
            r_dvd  <= {r_dvd[XLEN-2:0], 1'b0};
            r_quot <= {r_quot[XLEN-2:0], w_qbit};
            r_cnt  <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST)
              r_state <= SIGN;
          end
        end
        SIGN: begin
          if (FlushE) begin
            r_state <= IDLE;
          end else begin
            r_result <= r_is_rem ? w_r_fix : w_q_fix;
            r_div_rd <= r_rd;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign StallDivE    = w_accept | (r_state == CALC) | (r_state == SIGN);
  assign BusyE        = (r_state != IDLE);
  assign DoneE        = r_done;
  assign DivRegWriteE = r_done;
  assign DivResultE   = r_result;
  assign DivRdE       = r_div_rd;

endmodule
